n64_vsync_gen: RTL and testbench
================================

Name: n64_vsync_gen

Overview:
- Synthetic N64 video-bus transmitter: generates the nVDSYNC-framed 7-bit VD stream, i.e. a sync nibble followed by R, G and B per pixel slot.
- Timing is NTSC or PAL, 240p/288p or 480i/576i, selected by a 2-bit mode vector.
- Used as an internal test-pattern source and a bench stimulus for the PPU front end.
- Its sync behaviour is arranged so that our video-info extraction logic decodes palmode and n64_480i exactly.

Parameters:
- H_TOTAL_NTSC, 773, pixel slots per NTSC line
- H_TOTAL_PAL, 787, pixel slots per PAL line
- HSYNC_LEN, 57, slots nHSYNC held low from line start
- CLAMP_START, 64, first slot of nCLAMP low
- CLAMP_LEN, 16, slots nCLAMP held low
- VSYNC_HL, 6, half-lines nVSYNC held low from field start
- H_ACTIVE_START, 128, first slot with non-zero colour

Ports:
- VCLK  in  1  video clock
- nRST  in  1  asynchronous active-low reset
- vinfo_i  in  2  requested mode, order {palmode, n64_480i}
- nVDSYNC  out  1  low for one VCLK at each slot's sync phase
- VD_o  out  7  sync nibble {3'b000, nVSYNC, nCLAMP, nHSYNC, nCSYNC} at sync phase, else colour
- field_o  out  1  current field id, toggles at every field start
- vinfo_o  out  2  mode currently in effect, {palmode, n64_480i}

Behaviour:
- One clock (VCLK); reset is asynchronous, active-low (nRST).
- Reset values:
  - phase = 0, h = 0, hl = 0, mode = 2'b00
  - nVDSYNC = 1, VD_o = 7'h0F, field_o = 0, vinfo_o = 2'b00
- All outputs are registered. Outputs in cycle k+1 reflect the counter state in cycle k.
- phase counter (2 bits): 0, 1, 2, 3, wrap.
  - phase 0: nVDSYNC <= 0, VD_o <= sync nibble.
  - phases 1/2/3: nVDSYNC <= 1, VD_o <= R/G/B respectively.
- h (10 bits) counts slots; it increments when phase == 3.
  - Wraps to 0 at H_TOTAL-1, where H_TOTAL = mode[1] ? H_TOTAL_PAL : H_TOTAL_NTSC.
  - H_HALF = H_TOTAL >> 1.
- hl (10 bits) counts half-lines in the field.
  - Increments on slot entry to h == 0 and to h == H_HALF.
  - Wraps to 0 when reaching HL_FIELD:
    - NTSC 240p: 526
    - NTSC 480i: 525
    - PAL 288p: 626
    - PAL 576i: 625
  - Odd counts in interlaced modes alternate field starts between h = 0 and h = H_HALF.
- Field start is the slot where hl wraps to 0. field_o toggles there.
- Mode latch:
  - mode <= vinfo_i only at a field start that coincides with h == 0.
  - The first slot after reset is defined as such a field start.
  - Changes of vinfo_i at other times are ignored until the next aligned field start.
  - This guarantees a 480i→240p change never leaves 240p fields mid-line aligned.
- Sync nibble for the slot:
  - nHSYNC = !(h < HSYNC_LEN).
  - nVSYNC = !(hl < VSYNC_HL).
  - nCLAMP = !(nVSYNC && h in [CLAMP_START, CLAMP_START+CLAMP_LEN)).
  - nCSYNC = nVSYNC ? nHSYNC : !nHSYNC.
- Resulting decode properties:
  - nVSYNC falls at a field start. In 240p this always coincides with an nHSYNC fall. In 480i it coincides on alternate fields only.
  - nHSYNC falls between consecutive nVSYNC falls, excluding a coincident one:
    - NTSC: 262 or 263 (count mod 4 ∈ {2,3})
    - PAL: 312 or 313 (count mod 4 ∈ {0,1})
- Colour:
  - Zero while nHSYNC, nVSYNC or nCLAMP is low, or h < H_ACTIVE_START.
  - Otherwise R = h[6:0], G = hl[7:1], B = {7{field_o}}.
- Reset mid-line forces all counters and outputs to reset values immediately. Restart is at phase 0, field start, with the mode re-latched.

Test Plan:
- Reset release, vinfo_i = 2'b00 → nVDSYNC pattern 0,1,1,1 repeating from the first cycle; first sync nibble has nVSYNC = 0, nHSYNC = 0; line period 3092 VCLK; 262 nHSYNC falls between nVSYNC falls; every nVSYNC fall coincides with an nHSYNC fall.
- vinfo_i = 2'b10 (PAL 288p) → line period 3148 VCLK; 312 nHSYNC falls per field (mod 4 = 0); vinfo_o = 2'b10 after the first aligned field start.
- vinfo_i = 2'b01 (NTSC 480i) → fields alternate nVSYNC fall at h = 0 and at h = 386; field_o toggles each field; falls per field alternate 262/263.
- Switch vinfo_i from 2'b01 to 2'b00 during a mid-line-aligned field → vinfo_o holds 2'b01 until the next h = 0 field start, then becomes 2'b00; all later fields are h = 0 aligned.
- During hl < 6 → nCLAMP stays high, nCSYNC = !nHSYNC, colour phases output 7'h00.
- Assert nRST at arbitrary h → same cycle nVDSYNC = 1, VD_o = 7'h0F, field_o = 0; sequence after release is identical to the first scenario.

Source files
------------

// File: rtl/n64_vsync_gen.sv
// n64_vsync_gen: synthetic N64 video-bus transmitter.
// Drives the nVDSYNC-framed 7-bit VD stream. Each pixel slot is four VCLK
// cycles: a sync nibble {3'b000, nVSYNC, nCLAMP, nHSYNC, nCSYNC}, then the
// R, G and B values. Supports NTSC/PAL and progressive/interlaced timing.
// Ports:
//   VCLK     in   video clock
//   nRST     in   asynchronous active-low reset
//   vinfo_i  in   requested mode {palmode, n64_480i}
//   nVDSYNC  out  low for one VCLK at each slot's sync phase
//   VD_o     out  sync nibble during the sync phase, colour otherwise
//   field_o  out  field id, toggles at every field start
//   vinfo_o  out  mode currently in effect {palmode, n64_480i}
module n64_vsync_gen #(
  parameter int H_TOTAL_NTSC   = 773,
  parameter int H_TOTAL_PAL    = 787,
  parameter int HSYNC_LEN      = 57,
  parameter int CLAMP_START    = 64,
  parameter int CLAMP_LEN      = 16,
  parameter int VSYNC_HL       = 6,
  parameter int H_ACTIVE_START = 128
) (
  input  logic       VCLK,
  input  logic       nRST,
  input  logic [1:0] vinfo_i,
  output logic       nVDSYNC,
  output logic [6:0] VD_o,
  output logic       field_o,
  output logic [1:0] vinfo_o
);

  localparam logic [9:0] HT_N     = 10'(H_TOTAL_NTSC);
  localparam logic [9:0] HT_P     = 10'(H_TOTAL_PAL);
  localparam logic [9:0] HS_LEN   = 10'(HSYNC_LEN);
  localparam logic [9:0] CL_START = 10'(CLAMP_START);
  localparam logic [9:0] CL_END   = 10'(CLAMP_START + CLAMP_LEN);
  localparam logic [9:0] VS_HL    = 10'(VSYNC_HL);
  localparam logic [9:0] ACT      = 10'(H_ACTIVE_START);

  logic [1:0] phase;
  logic [9:0] h, hl;
  logic [1:0] mode;
  logic       field;

  logic [9:0] h_total, h_half, hl_field, h_nxt, hl_inc, hl_nxt;
  logic       h_last, hl_step, hl_wrap;
  logic       n_hsync, n_vsync, n_clamp, n_csync, blank;
  logic [6:0] sync_nib, col;

  always_comb begin
    h_total = mode[1] ? HT_P : HT_N;
    h_half  = {1'b0, h_total[9:1]};
    // Odd half-line counts in interlaced modes make successive field starts
    // alternate between h = 0 and h = h_half.
    case (mode)
      2'b00:   hl_field = 10'd526;
      2'b01:   hl_field = 10'd525;
      2'b10:   hl_field = 10'd626;
      default: hl_field = 10'd625;
    endcase
    h_last  = (h == h_total - 10'd1);
    h_nxt   = h_last ? 10'd0 : h + 10'd1;
    hl_step = h_last || (h_nxt == h_half);
    hl_inc  = hl + 10'd1;
    hl_wrap = hl_step && (hl_inc == hl_field);
    hl_nxt  = hl_wrap ? 10'd0 : (hl_step ? hl_inc : hl);

    n_hsync  = (h >= HS_LEN);
    n_vsync  = (hl >= VS_HL);
    n_clamp  = !(n_vsync && (h >= CL_START) && (h < CL_END));
    n_csync  = n_vsync ? n_hsync : !n_hsync;
    sync_nib = {3'b000, n_vsync, n_clamp, n_hsync, n_csync};

    blank = !n_hsync || !n_vsync || !n_clamp || (h < ACT);
    case (phase)
      2'd1:    col = h[6:0];
      2'd2:    col = hl[7:1];
      2'd3:    col = {7{field}};
      default: col = 7'h00;
    endcase
    if (blank) col = 7'h00;
  end

  always_ff @(posedge VCLK or negedge nRST) begin
    if (!nRST) begin
      phase   <= 2'd0;
      h       <= 10'd0;
      hl      <= 10'd0;
      mode    <= 2'b00;
      field   <= 1'b0;
      nVDSYNC <= 1'b1;
      VD_o    <= 7'h0F;
      field_o <= 1'b0;
      vinfo_o <= 2'b00;
    end else begin
      phase <= phase + 2'd1;
      // h == 0 && hl == 0 only occurs in a field that started line-aligned
      // (and in the first slot after reset), so mode never changes while a
      // field starts mid-line.
      if (phase == 2'd0 && h == 10'd0 && hl == 10'd0) mode <= vinfo_i;
      if (phase == 2'd3) begin
        h  <= h_nxt;
        hl <= hl_nxt;
        if (hl_wrap) field <= ~field;
      end
      nVDSYNC <= (phase != 2'd0);
      VD_o    <= (phase == 2'd0) ? sync_nib : col;
      field_o <= field;
      vinfo_o <= mode;
    end
  end

endmodule

// File: tb/tb_n64_vsync_gen.sv
`timescale 1ns/1ps
module tb_n64_vsync_gen;
  // Shrunk line geometry keeps whole fields short; half-line counts per
  // field are fixed by the design. NTSC line = 20 VCLK, H_HALF = 2 slots;
  // PAL line = 28 VCLK.
  localparam int HTN = 5, HTP = 7, HSL = 1, CLS = 2, CLL = 1, VSH = 6, HAS = 3;

  logic       VCLK = 1'b0;
  logic       nRST = 1'b0;
  logic [1:0] vinfo_i = 2'b00;
  logic       nVDSYNC;
  logic [6:0] VD_o;
  logic       field_o;
  logic [1:0] vinfo_o;

  always #5 VCLK = ~VCLK;

  n64_vsync_gen #(
    .H_TOTAL_NTSC(HTN), .H_TOTAL_PAL(HTP), .HSYNC_LEN(HSL), .CLAMP_START(CLS),
    .CLAMP_LEN(CLL), .VSYNC_HL(VSH), .H_ACTIVE_START(HAS)
  ) dut (
    .VCLK(VCLK), .nRST(nRST), .vinfo_i(vinfo_i), .nVDSYNC(nVDSYNC),
    .VD_o(VD_o), .field_o(field_o), .vinfo_o(vinfo_o)
  );

  // One record per nVSYNC fall. raw: nHSYNC falls in [this start, next
  // start); ex: same without a fall coincident with the start; off: VCLKs
  // from the last nHSYNC fall to the nVSYNC fall; per: last line period;
  // vprev/vin: vinfo_o at the fall and one VCLK later; inv: slot-level
  // violations seen during the field. -1 = not checked.
  typedef struct {
    int raw, ex, off, fld, vin, vprev, per, inv;
  } rec_t;

  rec_t exp_q[$];
  int checks = 0, errors = 0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  function automatic rec_t mk(input int raw, ex, off, fld, vin, vprev, per);
    rec_t r;
    r.raw = raw; r.ex = ex; r.off = off; r.fld = fld;
    r.vin = vin; r.vprev = vprev; r.per = per; r.inv = 0;
    return r;
  endfunction

  // ---------------- monitor ----------------
  int   cyc, last_hs, cnt_raw, cnt_ex, period, slot_h, line_l, ph, inv_bad, rec_n;
  bit   pvs, phs, cur_vs, aligned, pending, have_hs;
  bit   vs, cl, hs, cs, hs_fall, vs_fall, blank;
  int   ec;
  rec_t obs, e;

  initial begin
    inv_bad = 0;
    rec_n   = 0;
    forever begin
      @(negedge VCLK);
      if (!nRST) begin
        cyc = 0; pvs = 1; phs = 1; have_hs = 0; cnt_raw = 0; cnt_ex = 0;
        period = -1; slot_h = 0; line_l = 0; ph = 0; pending = 0;
        aligned = 0; cur_vs = 1;
      end else begin
        cyc++;
        if (pending) begin
          pending = 0;
          obs.vin = int'(vinfo_o);
          if (exp_q.size() == 0) chk("unexpected_field_start", 1, 0);
          else begin
            e = exp_q.pop_front();
            rec_n++;
            if (e.raw >= 0)   chk($sformatf("rec%0d_hsync_falls_raw", rec_n), obs.raw, e.raw);
            if (e.ex >= 0)    chk($sformatf("rec%0d_hsync_falls", rec_n), obs.ex, e.ex);
            if (e.off >= 0)   chk($sformatf("rec%0d_vs_offset", rec_n), obs.off, e.off);
            if (e.per >= 0)   chk($sformatf("rec%0d_line_period", rec_n), obs.per, e.per);
            chk($sformatf("rec%0d_field", rec_n), obs.fld, e.fld);
            chk($sformatf("rec%0d_vinfo_at_fall", rec_n), obs.vprev, e.vprev);
            chk($sformatf("rec%0d_vinfo_after", rec_n), obs.vin, e.vin);
            chk($sformatf("rec%0d_slot_violations", rec_n), obs.inv, e.inv);
          end
        end
        if (!nVDSYNC) begin
          vs = VD_o[3]; cl = VD_o[2]; hs = VD_o[1]; cs = VD_o[0];
          hs_fall = phs && !hs;
          vs_fall = pvs && !vs;
          if (VD_o[6:4] != 3'b000) inv_bad++;
          if (ph != 0 && ph != 4) inv_bad++;
          if (vs_fall) begin
            obs.raw = cnt_raw; obs.ex = cnt_ex;
            obs.off = hs_fall ? 0 : cyc - last_hs;
            obs.fld = int'(field_o); obs.vprev = int'(vinfo_o);
            obs.per = period; obs.inv = inv_bad;
            inv_bad = 0; pending = 1;
            cnt_raw = 0; cnt_ex = 0; aligned = hs_fall; line_l = 0;
          end else if (hs_fall) line_l++;
          if (hs_fall) begin
            cnt_raw++;
            if (!vs_fall) cnt_ex++;
            if (have_hs) period = cyc - last_hs;
            last_hs = cyc; have_hs = 1; slot_h = 0;
          end else slot_h++;
          if (hs != (slot_h >= HSL)) inv_bad++;
          if (!vs) begin
            if (!cl || cs != !hs) inv_bad++;
          end else begin
            if (cs != hs || cl != (slot_h != CLS)) inv_bad++;
          end
          cur_vs = vs; pvs = vs; phs = hs; ph = 1;
        end else begin
          if (ph < 1 || ph > 3) inv_bad++;
          else begin
            blank = !cur_vs || slot_h < HAS;
            ec = -1;
            if (ph == 1) ec = blank ? 0 : (slot_h % 128);
            if (ph == 2 && aligned) ec = blank ? 0 : (line_l % 128);
            if (ph == 3) ec = blank ? 0 : (field_o ? 127 : 0);
            if (ec >= 0 && int'(VD_o) != ec) inv_bad++;
          end
          ph++;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_empty(input int budget, input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge VCLK);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk({tag, "_timeout"}, exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic startup_check();
    for (int i = 0; i < 8; i++) begin
      @(negedge VCLK);
      chk("vdsync_pattern", int'(nVDSYNC), (i % 4 == 0) ? 0 : 1);
      if (i == 0) chk("first_nibble", int'(VD_o), 5);
    end
  endtask

  task automatic restart(input logic [1:0] v);
    @(negedge VCLK);
    #1 nRST = 1'b0;
    vinfo_i = v;
    repeat (2) @(negedge VCLK);
    #1 nRST = 1'b1;
  endtask

  initial begin
    // NTSC 240p from power-on reset.
    repeat (2) @(negedge VCLK);
    chk("rst_nvdsync", int'(nVDSYNC), 1);
    chk("rst_vd", int'(VD_o), 15);
    chk("rst_field", int'(field_o), 0);
    chk("rst_vinfo", int'(vinfo_o), 0);
    exp_q.push_back(mk(-1, -1, 0, 0, 0, 0, -1));
    exp_q.push_back(mk(263, 262, 0, 1, 0, 0, 20));
    exp_q.push_back(mk(263, 262, 0, 0, 0, 0, 20));
    @(negedge VCLK);
    #1 nRST = 1'b1;
    startup_check();
    wait_empty(20000, "ntsc240p");

    // PAL 288p.
    exp_q.push_back(mk(-1, -1, 0, 0, 2, 0, -1));
    exp_q.push_back(mk(313, 312, 0, 1, 2, 2, 28));
    restart(2'b10);
    wait_empty(15000, "pal288p");

    // Asynchronous reset mid-line while field_o = 1, then a 240p restart.
    repeat (37) @(posedge VCLK);
    #3 nRST = 1'b0;
    #1;
    chk("midrst_nvdsync", int'(nVDSYNC), 1);
    chk("midrst_vd", int'(VD_o), 15);
    chk("midrst_field", int'(field_o), 0);
    chk("midrst_vinfo", int'(vinfo_o), 0);
    vinfo_i = 2'b00;
    exp_q.push_back(mk(-1, -1, 0, 0, 0, 0, -1));
    exp_q.push_back(mk(263, 262, 0, 1, 0, 0, 20));
    @(negedge VCLK);
    #1 nRST = 1'b1;
    startup_check();
    wait_empty(10000, "restart240p");

    // NTSC 480i: starts alternate h = 0 / h = H_HALF (8 VCLK after the
    // nHSYNC fall). Raw counts include a fall coincident with the field
    // start, so aligned fields give 263 and mid-line fields 262.
    exp_q.push_back(mk(-1, -1, 0, 0, 1, 0, -1));
    exp_q.push_back(mk(263, 262, 8, 1, 1, 1, 20));
    exp_q.push_back(mk(262, 262, 0, 0, 1, 1, 20));
    exp_q.push_back(mk(263, 262, 8, 1, 1, 1, 20));
    // vinfo_i -> 00 during the mid-line field: takes effect at the next
    // aligned start, after which fields stay aligned.
    exp_q.push_back(mk(262, 262, 0, 0, 0, 1, 20));
    exp_q.push_back(mk(263, 262, 0, 1, 0, 0, 20));
    restart(2'b01);
    begin
      int n = 0;
      while (exp_q.size() > 2 && n < 20000) begin
        @(posedge VCLK);
        n++;
      end
    end
    vinfo_i = 2'b00;
    wait_empty(15000, "ntsc480i_switch");

    chk("trailing_slot_violations", inv_bad, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
